// File: rtl/iq_capture.sv
// I/Q sample capture buffer. It arms on request, stores a programmed number of
// {Q, I} samples, and then streams them back out over a valid/ready read port.
module iq_capture #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              GCLK,
   input  logic              reset,
   input  logic              MODULE_ENA,
   input  logic [DATA_W-1:0] DDS_IN,
   input  logic              DDS_DATA_VALID,
   input  logic              ARM,
   input  logic [ADDR_W-1:0] CAPTURE_LEN,
   input  logic              RD_READY,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic              BUSY,
   output logic              DONE,
   output logic              GAP_ERR,
   output logic [ADDR_W:0]   WR_CNT
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      READOUT
   } state_t;

   state_t state, next_state;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] mem_q;
   logic              q_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   len_m1;
   logic [ADDR_W:0]   wr_cnt;
   logic [ADDR_W:0]   wr_cnt_inc;
   logic [ADDR_W:0]   rd_issue;
   logic [ADDR_W:0]   xfer_cnt;
   logic              gap_err;
   logic              done_q;

   logic accept_arm;
   logic wr_en;
   logic wr_last;
   logic xfer;
   logic last_xfer;
   logic q_move;
   logic rd_en;

   // The RAM output register (mem_q) acts as a prefetch stage in front of the
   // output register, so reads are only issued when mem_q is free or draining.
   always_comb begin
      wr_cnt_inc = wr_cnt + 1'b1;
      len_m1     = len_q - 1'b1;
      accept_arm = (state == IDLE) && ARM && MODULE_ENA && !done_q;
      wr_en      = MODULE_ENA && DDS_DATA_VALID && ((state == ARMED) || (state == CAPTURE));
      wr_last    = wr_en && (wr_cnt_inc == len_q);
      xfer       = out_valid && RD_READY;
      last_xfer  = xfer && (xfer_cnt == len_m1);
      q_move     = q_valid && (!out_valid || xfer);
      rd_en      = (state == READOUT) && MODULE_ENA && (rd_issue != len_q) && (!q_valid || q_move);
   end

   always_comb begin
      next_state = state;
      if (!MODULE_ENA) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept_arm) next_state = ARMED;
            ARMED:   if (wr_en) next_state = wr_last ? READOUT : CAPTURE;
            CAPTURE: if (wr_last) next_state = READOUT;
            READOUT: if (last_xfer) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge GCLK or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge GCLK or negedge reset) begin
      if (!reset) begin
         len_q     <= '0;
         wr_cnt    <= '0;
         gap_err   <= 1'b0;
         done_q    <= 1'b0;
         q_valid   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         rd_issue  <= '0;
         xfer_cnt  <= '0;
      end else begin
         done_q <= MODULE_ENA && (state == READOUT) && last_xfer;

         if (accept_arm) begin
            len_q   <= (CAPTURE_LEN == '0) ? FULL_LEN : {1'b0, CAPTURE_LEN};
            wr_cnt  <= '0;
            gap_err <= 1'b0;
         end else begin
            if (wr_en) begin
               wr_cnt <= wr_cnt_inc;
            end
            if (MODULE_ENA && (state == CAPTURE) && !DDS_DATA_VALID) begin
               gap_err <= 1'b1;
            end
         end

         // Leaving READOUT for any reason, including abort, discards the pipeline.
         if ((state != READOUT) || !MODULE_ENA) begin
            q_valid   <= 1'b0;
            out_valid <= 1'b0;
            rd_issue  <= '0;
            xfer_cnt  <= '0;
         end else begin
            if (rd_en) begin
               rd_issue <= rd_issue + 1'b1;
            end
            if (xfer) begin
               xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (rd_en) begin
               q_valid <= 1'b1;
            end else if (q_move) begin
               q_valid <= 1'b0;
            end
            if (q_move) begin
               out_valid <= 1'b1;
               out_data  <= mem_q;
            end else if (xfer) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge GCLK) begin
      if (wr_en) begin
         mem[wr_cnt[ADDR_W-1:0]] <= DDS_IN;
      end
      if (rd_en) begin
         mem_q <= mem[rd_issue[ADDR_W-1:0]];
      end
   end

   assign RD_DATA  = out_data;
   assign RD_VALID = out_valid;
   assign BUSY     = (state != IDLE);
   assign DONE     = done_q;
   assign GAP_ERR  = gap_err;
   assign WR_CNT   = wr_cnt;

endmodule
